// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
// A slot mirrors one in-flight instruction; the selects name the EXE operand source.
package hazard_pkg;

   localparam int REG_W_DEF = 4;

   localparam logic [1:0] SEL_REGFILE = 2'b00;
   localparam logic [1:0] SEL_MEM     = 2'b01;
   localparam logic [1:0] SEL_WB      = 2'b10;

   typedef struct packed {
      logic                 valid;
      logic [REG_W_DEF-1:0] dest;
      logic                 mem_r_en;
      logic [REG_W_DEF-1:0] src_1;
      logic [REG_W_DEF-1:0] src_2;
      logic                 two_src;
   } slot_t;

   // MEM holds the younger result, so it wins over WB.
   function automatic logic [1:0] fwd_select(input logic mem_hit, input logic wb_hit);
      if (mem_hit) return SEL_MEM;
      if (wb_hit)  return SEL_WB;
      return SEL_REGFILE;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side query/response bundle of the hazard scoreboard.
// master = decode/pipeline control, slave = the scoreboard.
interface hazard_scoreboard_if
   import hazard_pkg::*;
#(
   parameter int REG_W = REG_W_DEF,
   parameter int CNT_W = 16
);
   logic [REG_W-1:0] src_1;
   logic [REG_W-1:0] src_2;
   logic             two_src;
   logic [REG_W-1:0] id_dest;
   logic             id_wb_en;
   logic             id_mem_r_en;
   logic             freeze;
   logic             flush;
   logic             hazard;
   logic [1:0]       sel_src_1;
   logic [1:0]       sel_src_2;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output src_1, src_2, two_src, id_dest, id_wb_en, id_mem_r_en, freeze, flush,
      input  hazard, sel_src_1, sel_src_2, stall_cnt
   );

   modport slave (
      input  src_1, src_2, two_src, id_dest, id_wb_en, id_mem_r_en, freeze, flush,
      output hazard, sel_src_1, sel_src_2, stall_cnt
   );
endinterface

// File: rtl/hazard_src_match.sv
// Single source-versus-slot comparator: hit when the slot is live and writes src.
module hazard_src_match #(
   parameter int REG_W = 4
) (
   input  logic [REG_W-1:0] src,
   input  logic             vld,
   input  logic [REG_W-1:0] dest,
   output logic             hit
);
   assign hit = vld && (dest == src);
endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks EXE/MEM/WB destinations; hazard is combinational, slots advance one edge later and hold on freeze.
// HAZARD_SCOREBOARD_FORWARDING_EN: load-use-only stalls plus EXE forwarding selects.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_W = REG_W_DEF,
   parameter int CNT_W = 16
) (
   input logic                clk,
   input logic                rst,
   hazard_scoreboard_if.slave bus
);

   logic             kill;
   logic             exe_vld;
   logic [REG_W-1:0] exe_dest;
   logic             mem_vld_q;
   logic [REG_W-1:0] mem_dest_q;
   logic [CNT_W-1:0] cnt_q;

   // A stalled or annulled ID instruction enters EXE as a bubble.
   assign kill = bus.hazard | bus.flush;

`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
   slot_t            exe_q;
   logic             wb_vld_q;
   logic [REG_W-1:0] wb_dest_q;
   logic             s1_exe, s2_exe;
   logic             e1_mem, e1_wb, e2_mem, e2_wb;

   hazard_src_match #(.REG_W(REG_W)) u_s1_exe (.src(bus.src_1), .vld(exe_q.valid), .dest(exe_q.dest), .hit(s1_exe));
   hazard_src_match #(.REG_W(REG_W)) u_s2_exe (.src(bus.src_2), .vld(exe_q.valid), .dest(exe_q.dest), .hit(s2_exe));
   hazard_src_match #(.REG_W(REG_W)) u_e1_mem (.src(exe_q.src_1), .vld(mem_vld_q), .dest(mem_dest_q), .hit(e1_mem));
   hazard_src_match #(.REG_W(REG_W)) u_e1_wb  (.src(exe_q.src_1), .vld(wb_vld_q),  .dest(wb_dest_q),  .hit(e1_wb));
   hazard_src_match #(.REG_W(REG_W)) u_e2_mem (.src(exe_q.src_2), .vld(mem_vld_q), .dest(mem_dest_q), .hit(e2_mem));
   hazard_src_match #(.REG_W(REG_W)) u_e2_wb  (.src(exe_q.src_2), .vld(wb_vld_q),  .dest(wb_dest_q),  .hit(e2_wb));

   // Only a load still in EXE produces its data too late to forward.
   assign bus.hazard    = exe_q.mem_r_en & (s1_exe | (bus.two_src & s2_exe));
   assign bus.sel_src_1 = fwd_select(e1_mem, e1_wb);
   assign bus.sel_src_2 = exe_q.two_src ? fwd_select(e2_mem, e2_wb) : SEL_REGFILE;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exe_q     <= '0;
         wb_vld_q  <= 1'b0;
         wb_dest_q <= '0;
      end else if (!bus.freeze) begin
         exe_q     <= '{valid:    bus.id_wb_en & ~kill,
                        dest:     bus.id_dest,
                        mem_r_en: bus.id_mem_r_en & ~kill,
                        src_1:    bus.src_1,
                        src_2:    bus.src_2,
                        two_src:  bus.two_src};
         wb_vld_q  <= mem_vld_q;
         wb_dest_q <= mem_dest_q;
      end
   end

   assign exe_vld  = exe_q.valid;
   assign exe_dest = exe_q.dest;
`else
   logic             exe_vld_q;
   logic [REG_W-1:0] exe_dest_q;
   logic             s1_exe, s1_mem, s2_exe, s2_mem;

   hazard_src_match #(.REG_W(REG_W)) u_s1_exe (.src(bus.src_1), .vld(exe_vld_q), .dest(exe_dest_q), .hit(s1_exe));
   hazard_src_match #(.REG_W(REG_W)) u_s1_mem (.src(bus.src_1), .vld(mem_vld_q), .dest(mem_dest_q), .hit(s1_mem));
   hazard_src_match #(.REG_W(REG_W)) u_s2_exe (.src(bus.src_2), .vld(exe_vld_q), .dest(exe_dest_q), .hit(s2_exe));
   hazard_src_match #(.REG_W(REG_W)) u_s2_mem (.src(bus.src_2), .vld(mem_vld_q), .dest(mem_dest_q), .hit(s2_mem));

   // WB never stalls: the register file writes before decode reads it.
   assign bus.hazard    = s1_exe | s1_mem | (bus.two_src & (s2_exe | s2_mem));
   assign bus.sel_src_1 = SEL_REGFILE;
   assign bus.sel_src_2 = SEL_REGFILE;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exe_vld_q  <= 1'b0;
         exe_dest_q <= '0;
      end else if (!bus.freeze) begin
         exe_vld_q  <= bus.id_wb_en & ~kill;
         exe_dest_q <= bus.id_dest;
      end
   end

   assign exe_vld  = exe_vld_q;
   assign exe_dest = exe_dest_q;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_vld_q  <= 1'b0;
         mem_dest_q <= '0;
         cnt_q      <= '0;
      end else if (!bus.freeze) begin
         mem_vld_q  <= exe_vld;
         mem_dest_q <= exe_dest;
         if (bus.hazard && (cnt_q != '1))
            cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_hazard_scoreboard;
   import hazard_pkg::*;

   localparam int REG_W   = 4;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   hazard_scoreboard_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();
   hazard_scoreboard #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      bit v;
      bit ld;
      int dest;
      int s1;
      int s2;
      bit two;
   } ins_t;

   typedef struct {
      bit hz;
      int sel1;
      int sel2;
      int cnt;
   } exp_t;

   // In-flight instructions, youngest first: [0]=EXE, [1]=MEM, [2]=WB.
   ins_t pipe[$];
   int   cnt_m;
   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check_val(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic bit writes(input ins_t e, input int r);
      return e.v && (e.dest == r);
   endfunction

   function automatic bit model_hazard(input int s1, input int s2, input bit two);
      bit h;
      h = 1'b0;
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
      h = pipe[0].ld && (writes(pipe[0], s1) || (two && writes(pipe[0], s2)));
`else
      for (int k = 0; k < 2; k++)
         if (writes(pipe[k], s1) || (two && writes(pipe[k], s2))) h = 1'b1;
`endif
      return h;
   endfunction

   function automatic int fwd_sel(input int s);
      if (writes(pipe[1], s)) return 1;
      if (writes(pipe[2], s)) return 2;
      return 0;
   endfunction

   task automatic reset_model();
      ins_t z;
      z = '{default: 0};
      pipe.delete();
      for (int k = 0; k < 3; k++) pipe.push_back(z);
      cnt_m = 0;
   endtask

   task automatic step(input int s1, input int s2, input bit two, input int dest,
                       input bit wb, input bit mr, input bit frz, input bit fl, input bit rs);
      exp_t e;
      ins_t n;
      bit   hz;
      bit   kill;
      @(posedge clk);
      #1;
      rst             = rs;
      bus.src_1       = REG_W'(s1);
      bus.src_2       = REG_W'(s2);
      bus.two_src     = two;
      bus.id_dest     = REG_W'(dest);
      bus.id_wb_en    = wb;
      bus.id_mem_r_en = mr;
      bus.freeze      = frz;
      bus.flush       = fl;
      if (!rs) reset_model();
      hz = model_hazard(s1, s2, two);
      e.hz   = hz;
      e.cnt  = cnt_m;
      e.sel1 = 0;
      e.sel2 = 0;
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
      e.sel1 = fwd_sel(pipe[0].s1);
      e.sel2 = pipe[0].two ? fwd_sel(pipe[0].s2) : 0;
`endif
      exp_q.push_back(e);
      // State the model will hold after the coming edge.
      if (rs && !frz) begin
         kill = hz || fl;
         n = '{v: wb && !kill, ld: mr && !kill, dest: dest, s1: s1, s2: s2, two: two};
         pipe.push_front(n);
         void'(pipe.pop_back());
         if (hz && cnt_m < CNT_MAX) cnt_m++;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("hazard",    int'(bus.hazard),    int'(e.hz));
            check_val("sel_src_1", int'(bus.sel_src_1), e.sel1);
            check_val("sel_src_2", int'(bus.sel_src_2), e.sel2);
            check_val("stall_cnt", int'(bus.stall_cnt), e.cnt);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
      $fatal(1);
   end

   initial begin : stimulus
      bus.src_1 = '0; bus.src_2 = '0; bus.two_src = 1'b0; bus.id_dest = '0;
      bus.id_wb_en = 1'b0; bus.id_mem_r_en = 1'b0; bus.freeze = 1'b0; bus.flush = 1'b0;
      reset_model();

      // reset, then ALU write R3 followed by a reader of R3
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 3, 1, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(3, 0, 0, 4, 1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
      check_val("alu_dep_stalls", int'(bus.stall_cnt), 0);
`else
      check_val("alu_dep_stalls", int'(bus.stall_cnt), 2);
`endif
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);

      // load R5, consumer on src_2 with two_src
      step(0, 0, 0, 5, 1, 1, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(1, 5, 1, 6, 1, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);

      // src_2 matches EXE dest but is not a real operand
      step(0, 0, 0, 8, 1, 1, 0, 0, 1);
      step(1, 8, 0, 2, 1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);

      // freeze for three cycles while a load-use hazard is pending
      step(0, 0, 0, 7, 1, 1, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(7, 0, 0, 9, 1, 0, 1, 0, 1);
      for (int i = 0; i < 3; i++) step(7, 0, 0, 9, 1, 0, 0, 0, 1);

      // flushed writer must not stall a later reader
      step(0, 0, 0, 11, 1, 1, 0, 1, 1);
      step(11, 11, 1, 12, 1, 0, 0, 0, 1);
      step(11, 0, 0, 13, 1, 0, 0, 0, 1);

      // reset mid-stream while a stall is pending, then resume
      step(0, 0, 0, 4, 1, 1, 0, 0, 1);
      step(4, 0, 0, 5, 1, 0, 0, 0, 0);
      step(4, 0, 0, 5, 1, 0, 0, 0, 1);
      step(5, 0, 0, 6, 1, 0, 0, 0, 1);

      // load/consumer pairs drive the counter into saturation
      for (int i = 0; i < 20; i++) begin
         step(2, 0, 0, 1, 1, 1, 0, 0, 1);
         step(1, 0, 0, 6, 1, 0, 0, 0, 1);
      end

      for (int i = 0; i < 700; i++) begin
         step($urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
              $urandom_range(0, 5), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 63) != 0));
      end

      @(negedge clk);
      @(negedge clk);
      check_val("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
